// File: rtl/rtf64_pic_pkg.sv
// Shared constants and types for the rtf64 programmable interrupt controller.
package rtf64_pic_pkg;

  localparam int PIC_NSRC = 16;

  // Word offsets, decoded from adr_i[4:2]
  localparam logic [2:0] PIC_PEND  = 3'd0;
  localparam logic [2:0] PIC_EN    = 3'd1;
  localparam logic [2:0] PIC_EDGE  = 3'd2;
  localparam logic [2:0] PIC_CTRL  = 3'd3;
  localparam logic [2:0] PIC_CAUSE = 3'd4;
  localparam logic [2:0] PIC_SWSET = 3'd5;

  typedef logic [PIC_NSRC-1:0] pic_vec_t;

endpackage

// File: rtl/rtf64_pic_prienc.sv
// 16-to-4 priority encoder: the highest set index wins; idx is 0 when nothing is set.
module rtf64_pic_prienc
  import rtf64_pic_pkg::*;
(
  input  pic_vec_t   req,
  output logic [3:0] idx,
  output logic       any
);

  always_comb begin
    idx = '0;
    for (int i = 0; i < PIC_NSRC; i++)
      if (req[i]) idx = i[3:0];
    any = |req;
  end

endmodule

// File: rtl/rtf64_pic.sv
// rtf64 interrupt controller: edge/level latching, masking and priority of 16 sources.
// Optional RTF64_PIC_NMI_EN turns source 15 into a non-maskable edge source on nmi_o.
module rtf64_pic
  import rtf64_pic_pkg::*;
(
  input  logic        rst_i,
  input  logic        clk_i,
  input  logic        cs_i,
  input  logic        cyc_i,
  input  logic        stb_i,
  output logic        ack_o,
  input  logic [3:0]  sel_i,
  input  logic        we_i,
  input  logic [4:0]  adr_i,
  input  logic [31:0] dat_i,
  output logic [31:0] dat_o,
  input  pic_vec_t    irq_i,
  output logic        irq_o,
  output logic [3:0]  cause_o
`ifdef RTF64_PIC_NMI_EN
  , output logic      nmi_o
`endif
);

`ifdef RTF64_PIC_NMI_EN
  localparam pic_vec_t NMI_MASK = 16'h8000;
`else
  localparam pic_vec_t NMI_MASK = 16'h0000;
`endif

  pic_vec_t pend, en, edge_r, irq_s, prev;
  logic     gie, rd_ack_q;

  logic cs, wr;
  assign cs = cs_i & cyc_i & stb_i;
  assign wr = cs & we_i;
  // Reset gates the comb write ack so an interrupted access never acks
  assign ack_o = ~rst_i & cs & (we_i | rd_ack_q);

  logic wr_pend, wr_en, wr_edge, wr_ctrl, wr_swset;
  assign wr_pend  = wr && (adr_i[4:2] == PIC_PEND);
  assign wr_en    = wr && (adr_i[4:2] == PIC_EN);
  assign wr_edge  = wr && (adr_i[4:2] == PIC_EDGE);
  assign wr_ctrl  = wr && (adr_i[4:2] == PIC_CTRL);
  assign wr_swset = wr && (adr_i[4:2] == PIC_SWSET);

  pic_vec_t wm, wdat;
  assign wm   = {{8{sel_i[1]}}, {8{sel_i[0]}}};
  assign wdat = dat_i[15:0] & wm;

  logic unused_bus;
  assign unused_bus = ^{dat_i[31:16], sel_i[3:2], adr_i[1:0]};

  pic_vec_t edge_eff, edge_new, edge_chg, rise, clr, sws, pend_edge, pend_n;
  assign edge_eff  = edge_r | NMI_MASK;
  assign edge_new  = ((edge_r & ~wm) | wdat) & ~NMI_MASK;
  assign edge_chg  = wr_edge ? (edge_new ^ edge_r) : '0;
  // irq_s is the sampling stage; the edge detect works on it, not on raw irq_i
  assign rise      = irq_s & ~prev;
  assign clr       = wr_pend  ? wdat : '0;
  assign sws       = wr_swset ? wdat : '0;
  // Set (hardware or software) beats a same-cycle clear
  assign pend_edge = (pend & ~clr) | rise | sws;
  assign pend_n    = ((edge_eff & pend_edge) | (~edge_eff & irq_s)) & ~edge_chg;

  pic_vec_t   req;
  logic [3:0] win_idx;
  logic       win_any;
  assign req = pend & en & {PIC_NSRC{gie}} & ~NMI_MASK;

  rtf64_pic_prienc u_prienc (
    .req (req),
    .idx (win_idx),
    .any (win_any)
  );

  logic [31:0] rd_data;
  always_comb begin
    rd_data = '0;
    case (adr_i[4:2])
      PIC_PEND:  rd_data = {16'b0, pend};
      PIC_EN:    rd_data = {16'b0, en};
      PIC_EDGE:  rd_data = {16'b0, edge_eff};
      PIC_CTRL:  rd_data = {31'b0, gie};
      PIC_CAUSE: rd_data = {irq_o, 27'b0, cause_o};
      default:   rd_data = '0;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pend     <= '0;
      en       <= '0;
      edge_r   <= '0;
      gie      <= 1'b0;
      irq_s    <= '0;
      prev     <= '0;
      rd_ack_q <= 1'b0;
      dat_o    <= '0;
      irq_o    <= 1'b0;
      cause_o  <= '0;
    end else begin
      irq_s    <= irq_i;
      prev     <= irq_s;
      pend     <= pend_n;
      if (wr_en)   en     <= (en & ~wm) | wdat;
      if (wr_edge) edge_r <= edge_new;
      if (wr_ctrl && sel_i[0]) gie <= dat_i[0];
      rd_ack_q <= cs & ~we_i;
      if (cs && !we_i) dat_o <= rd_data;
      irq_o    <= win_any;
      cause_o  <= win_idx;
    end
  end

`ifdef RTF64_PIC_NMI_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) nmi_o <= 1'b0;
    else       nmi_o <= pend[PIC_NSRC-1];
  end
`endif

endmodule

// File: tb/tb_rtf64_pic.sv
// Directed bench for rtf64_pic: register table plus latency/priority corner sequences.
module tb_rtf64_pic;
  import rtf64_pic_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        cs_i = 1'b0, cyc_i = 1'b0, stb_i = 1'b0, we_i = 1'b0;
  logic [3:0]  sel_i = '0;
  logic [4:0]  adr_i = '0;
  logic [31:0] dat_i = '0;
  logic [31:0] dat_o;
  logic        ack_o, irq_o;
  logic [3:0]  cause_o;
  pic_vec_t    irq_i = '0;
`ifdef RTF64_PIC_NMI_EN
  logic        nmi_o;
  localparam logic [31:0] EDGE_RO = 32'h0000_8000;
`else
  localparam logic [31:0] EDGE_RO = 32'h0;
`endif

  int checks = 0;
  int errors = 0;

  rtf64_pic dut (
    .rst_i(rst_i), .clk_i(clk_i), .cs_i(cs_i), .cyc_i(cyc_i), .stb_i(stb_i),
    .ack_o(ack_o), .sel_i(sel_i), .we_i(we_i), .adr_i(adr_i), .dat_i(dat_i),
    .dat_o(dat_o), .irq_i(irq_i), .irq_o(irq_o), .cause_o(cause_o)
`ifdef RTF64_PIC_NMI_EN
    , .nmi_o(nmi_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d, input logic [3:0] s = 4'hf);
    @(negedge clk_i);
    cs_i = 1; cyc_i = 1; stb_i = 1; we_i = 1; adr_i = {a, 2'b00}; dat_i = d; sel_i = s;
    #1 check("wr_ack", {31'b0, ack_o}, 32'd1);
    @(posedge clk_i);
    #1 cs_i = 0; cyc_i = 0; stb_i = 0; we_i = 0;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    int n;
    @(negedge clk_i);
    cs_i = 1; cyc_i = 1; stb_i = 1; we_i = 0; adr_i = {a, 2'b00}; sel_i = 4'hf;
    n = 0;
    do begin
      @(posedge clk_i); #1; n++;
    end while (!ack_o && n < 4);
    if (!ack_o) check("rd_ack_timeout", 32'd0, 32'd1);
    d = dat_o;
    cs_i = 0; cyc_i = 0; stb_i = 0;
    #1 check("ack_drop", {31'b0, ack_o}, 32'd0);
    @(posedge clk_i); #1;
  endtask

  task automatic rd_check(input string nm, input logic [2:0] a, input logic [31:0] exp);
    logic [31:0] d;
    bus_read(a, d);
    check(nm, d, exp);
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  a;
    logic [3:0]  sel;
    logic [31:0] wd;
    logic [31:0] exp;
    string       nm;
  } vec_t;
  vec_t vq[$];

  task automatic add(input logic we, input logic [2:0] a, input logic [3:0] sel,
                     input logic [31:0] wd, input logic [31:0] exp, input string nm);
    vec_t v;
    v.we = we; v.a = a; v.sel = sel; v.wd = wd; v.exp = exp; v.nm = nm;
    vq.push_back(v);
  endtask

  initial begin
    logic [31:0] d;

    add(0, PIC_PEND,  4'hf, 0, 32'h0, "rst_pend");
    add(0, PIC_EN,    4'hf, 0, 32'h0, "rst_en");
    add(0, PIC_EDGE,  4'hf, 0, EDGE_RO, "rst_edge");
    add(0, PIC_CTRL,  4'hf, 0, 32'h0, "rst_ctrl");
    add(0, PIC_CAUSE, 4'hf, 0, 32'h0, "rst_cause");
    add(0, PIC_SWSET, 4'hf, 0, 32'h0, "rst_swset");
    add(1, PIC_EN,    4'hf, 32'hFFFF_1234, 0, "");
    add(0, PIC_EN,    4'hf, 0, 32'h0000_1234, "en_hi_lanes");
    add(1, PIC_EN,    4'h1, 32'h0000_56AB, 0, "");
    add(0, PIC_EN,    4'hf, 0, 32'h0000_12AB, "en_lane0");
    add(1, PIC_CTRL,  4'hf, 32'hFFFF_FFFE, 0, "");
    add(0, PIC_CTRL,  4'hf, 0, 32'h0, "ctrl_bit0");
    add(1, PIC_EN,    4'hf, 32'h0, 0, "");
    add(0, PIC_EN,    4'hf, 0, 32'h0, "en_clear");

    repeat (3) @(posedge clk_i);
    #1;
    check("rst_irq",   {31'b0, irq_o}, 32'd0);
    check("rst_cause_o", {28'b0, cause_o}, 32'd0);
    check("rst_ack",   {31'b0, ack_o}, 32'd0);
    check("rst_dat",   dat_o, 32'd0);
`ifdef RTF64_PIC_NMI_EN
    check("rst_nmi",   {31'b0, nmi_o}, 32'd0);
`endif
    @(negedge clk_i) rst_i = 0;

    foreach (vq[i]) begin
      if (vq[i].we) bus_write(vq[i].a, vq[i].wd, vq[i].sel);
      else begin
        bus_read(vq[i].a, d);
        check(vq[i].nm, d, vq[i].exp);
      end
    end

    // Level source: latency N+2 on rise and on fall
    bus_write(PIC_EN, 32'h4);
    bus_write(PIC_CTRL, 32'h1);
    @(negedge clk_i) irq_i = 16'h0004;
    @(posedge clk_i); #1 check("lvl_n0", {31'b0, irq_o}, 32'd0);
    @(posedge clk_i); #1 check("lvl_n1", {31'b0, irq_o}, 32'd0);
    @(posedge clk_i); #1 check("lvl_n2", {31'b0, irq_o}, 32'd1);
    check("lvl_cause", {28'b0, cause_o}, 32'd2);
    @(negedge clk_i) irq_i = 16'h0000;
    @(posedge clk_i);
    @(posedge clk_i); #1 check("lvl_fall_n1", {31'b0, irq_o}, 32'd1);
    @(posedge clk_i); #1 check("lvl_fall_n2", {31'b0, irq_o}, 32'd0);

    // Edge source: one-cycle pulse latches and holds
    bus_write(PIC_EDGE, 32'h7);
    bus_write(PIC_EN, 32'h7);
    @(negedge clk_i) irq_i = 16'h0001;
    @(negedge clk_i) irq_i = 16'h0000;
    repeat (3) @(posedge clk_i);
    rd_check("edge_pend", PIC_PEND, 32'h1);
    repeat (4) @(posedge clk_i);
    rd_check("edge_hold", PIC_PEND, 32'h1);
    check("edge_irq", {31'b0, irq_o}, 32'd1);
    check("edge_cause", {28'b0, cause_o}, 32'd0);
    bus_write(PIC_PEND, 32'h1);
    check("clr_n0", {31'b0, irq_o}, 32'd1);
    @(posedge clk_i); #1 check("clr_n1", {31'b0, irq_o}, 32'd0);

    // Priority between sources 1 and 9
    bus_write(PIC_EDGE, 32'h0207);
    bus_write(PIC_EN, 32'h0207);
    bus_write(PIC_SWSET, 32'h0202);
    @(posedge clk_i); #1 check("pri_cause9", {28'b0, cause_o}, 32'd9);
    rd_check("pri_cause_reg", PIC_CAUSE, 32'h8000_0009);
    bus_write(PIC_PEND, 32'h0200);
    @(posedge clk_i); #1 check("pri_cause1", {28'b0, cause_o}, 32'd1);
    check("pri_irq", {31'b0, irq_o}, 32'd1);
    bus_write(PIC_PEND, 32'h0002);

    // Rising edge on bit 3 coincides with a clear of bit 3
    bus_write(PIC_EDGE, 32'h020F);
    @(negedge clk_i) irq_i = 16'h0008;
    bus_write(PIC_PEND, 32'h0008);
    rd_check("set_beats_clr", PIC_PEND, 32'h0008);
    @(negedge clk_i) irq_i = 16'h0000;
    bus_write(PIC_PEND, 32'h0008);
    rd_check("clr_after", PIC_PEND, 32'h0);

    // swset ignored on a level source
    bus_write(PIC_SWSET, 32'h0010);
    rd_check("swset_level", PIC_PEND, 32'h0);

    // Software set while globally masked, then unmask
    bus_write(PIC_CTRL, 32'h0);
    bus_write(PIC_EDGE, 32'h022F);
    bus_write(PIC_EN, 32'h0020);
    bus_write(PIC_SWSET, 32'h0020);
    rd_check("sw_pend", PIC_PEND, 32'h0020);
    check("sw_masked", {31'b0, irq_o}, 32'd0);
    bus_write(PIC_CTRL, 32'h1);
    @(posedge clk_i); #1 check("sw_irq", {31'b0, irq_o}, 32'd1);
    check("sw_cause", {28'b0, cause_o}, 32'd5);

`ifdef RTF64_PIC_NMI_EN
    bus_write(PIC_SWSET, 32'h8000);
    @(posedge clk_i); #1 check("nmi_out", {31'b0, nmi_o}, 32'd1);
    check("nmi_excl", {28'b0, cause_o}, 32'd5);
`endif

    // Reset in the middle of a write cycle
    @(negedge clk_i);
    cs_i = 1; cyc_i = 1; stb_i = 1; we_i = 1; adr_i = {PIC_EN, 2'b00}; dat_i = 32'hFFFF; sel_i = 4'hf;
    #1 check("midrst_ack_pre", {31'b0, ack_o}, 32'd1);
    rst_i = 1;
    #1 check("midrst_ack", {31'b0, ack_o}, 32'd0);
    @(posedge clk_i);
    #1 cs_i = 0; cyc_i = 0; stb_i = 0; we_i = 0;
    @(negedge clk_i) rst_i = 0;
    rd_check("midrst_en", PIC_EN, 32'h0);
    rd_check("midrst_pend", PIC_PEND, 32'h0);
    check("midrst_irq", {31'b0, irq_o}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
